// File: rtl/swc_multiport_page_allocator.sv
`default_nettype none
// ============================================================================
// swc_multiport_page_allocator
//   Round-robin shared page allocator: LIFO free-page stack plus use-count RAM.
//   Optional macro: SWC_PALLOC_DBLFREE_CHECK_EN (reject release of free pages)
//   Rev 1.0 - initial release
// ============================================================================
module swc_multiport_page_allocator #(
   parameter int g_num_ports      = 4,
   parameter int g_num_pages      = 2048,
   parameter int g_page_addr_bits = 11,
   parameter int g_use_count_bits = 4,
   parameter int g_reserve_pages  = 16
) (
   input  logic                                     clk_i,
   input  logic                                     rst_n_i,
   input  logic [g_num_ports-1:0]                   alloc_i,
   input  logic [g_num_ports-1:0]                   free_i,
   input  logic [g_num_ports-1:0]                   force_free_i,
   input  logic [g_num_ports-1:0]                   set_usecnt_i,
   input  logic [g_num_ports*g_page_addr_bits-1:0]  pgaddr_i,
   input  logic [g_num_ports*g_use_count_bits-1:0]  usecnt_i,
   output logic [g_num_ports-1:0]                   done_o,
   output logic [g_page_addr_bits-1:0]              pgaddr_o,
   output logic                                     nomem_o,
   output logic                                     low_o,
   output logic [g_page_addr_bits:0]                free_count_o,
   output logic                                     idle_o,
   output logic                                     err_o
);

   localparam int c_p  = g_num_ports;
   localparam int c_a  = g_page_addr_bits;
   localparam int c_c  = g_use_count_bits;
   localparam int c_pw = (c_p > 1) ? $clog2(c_p) : 1;
   localparam logic [c_a:0]   c_npages  = (c_a+1)'(g_num_pages);
   localparam logic [c_a:0]   c_reserve = (c_a+1)'(g_reserve_pages);
   localparam logic [c_a-1:0] c_last    = c_a'(g_num_pages - 1);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE,
      S_ALLOC_RD, S_ALLOC_LAT, S_ALLOC_WR,
      S_FREE_RD, S_FREE_LAT, S_FREE_WR,
      S_SET_RD, S_SET_WR, S_DONE
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_a-1:0]      r_stack  [g_num_pages];
   logic [c_c-1:0]      r_usecnt [g_num_pages];
   logic [c_a-1:0]      r_stack_q;
   logic [c_c-1:0]      r_cnt_q;
   logic [c_a-1:0]      r_init_idx;
   logic [c_a:0]        r_top, w_top_nxt, w_top_m1;
   logic [c_pw-1:0]     r_port, r_last, w_sel;
   logic                r_force;
   logic [c_a-1:0]      r_addr, r_page;
   logic [c_c-1:0]      r_cnt_in, r_cnt;
   logic [c_p-1:0]      w_req, w_done_vec;
   logic                w_any, w_found;
   logic                w_push, w_pop, w_done, w_err;
   logic                w_stack_we, w_cnt_we;
   logic [c_a-1:0]      w_stack_waddr, w_stack_wdata, w_stack_raddr, w_cnt_waddr;
   logic [c_c-1:0]      w_cnt_wdata;

   assign w_req    = alloc_i | free_i | force_free_i | set_usecnt_i;
   assign w_any    = |w_req;
   assign idle_o   = (r_state == S_IDLE) && !w_any;
   assign free_count_o = r_top;
   assign w_top_m1 = r_top - (c_a+1)'(1);
   assign w_stack_raddr = (r_top == '0) ? '0 : w_top_m1[c_a-1:0];
   assign w_top_nxt = r_top + (c_a+1)'(w_push) - (c_a+1)'(w_pop);

   // Search starts one past the last grant so every requester is served in turn.
   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      for (int i = 1; i <= c_p; i++) begin
         if (!w_found && w_req[(int'(r_last) + i) % c_p]) begin
            w_found = 1'b1;
            w_sel   = c_pw'((int'(r_last) + i) % c_p);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < c_p; i++)
         w_done_vec[i] = w_done && (r_port == c_pw'(i));
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_stack_we    = 1'b0;
      w_stack_waddr = r_top[c_a-1:0];
      w_stack_wdata = r_addr;
      w_cnt_we      = 1'b0;
      w_cnt_waddr   = r_addr;
      w_cnt_wdata   = '0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_done        = 1'b0;
      w_err         = 1'b0;
      case (r_state)
         S_INIT: begin
            w_stack_we    = 1'b1;
            w_stack_waddr = r_init_idx;
            w_stack_wdata = c_last - r_init_idx;
            w_cnt_we      = 1'b1;
            w_cnt_waddr   = r_init_idx;
            w_push        = 1'b1;
            if (r_init_idx == c_last) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (w_any) begin
               if (force_free_i[w_sel] || free_i[w_sel]) w_state_nxt = S_FREE_RD;
               else if (set_usecnt_i[w_sel])             w_state_nxt = S_SET_RD;
               else                                      w_state_nxt = S_ALLOC_RD;
            end
         end
         S_ALLOC_RD:  w_state_nxt = S_ALLOC_LAT;
         S_ALLOC_LAT: w_state_nxt = S_ALLOC_WR;
         S_ALLOC_WR: begin
            w_done      = 1'b1;
            w_state_nxt = S_DONE;
            if (r_top == '0) begin
               w_err = 1'b1;
            end else begin
               w_pop       = 1'b1;
               w_cnt_we    = 1'b1;
               w_cnt_waddr = r_page;
               w_cnt_wdata = (r_cnt_in == '0) ? c_c'(1) : r_cnt_in;
            end
         end
         S_FREE_RD:  w_state_nxt = S_FREE_LAT;
         S_FREE_LAT: w_state_nxt = S_FREE_WR;
         S_FREE_WR: begin
            w_done      = 1'b1;
            w_state_nxt = S_DONE;
            if (r_cnt == '0) begin
`ifdef SWC_PALLOC_DBLFREE_CHECK_EN
               w_err = 1'b1;
`else
               if (r_top == c_npages) begin
                  w_err = 1'b1;
               end else begin
                  w_push     = 1'b1;
                  w_stack_we = 1'b1;
               end
`endif
            end else if (r_force || r_cnt == c_c'(1)) begin
               w_cnt_we = 1'b1;
               // A full stack means the client is releasing a page it never owned.
               if (r_top == c_npages) begin
                  w_err = 1'b1;
               end else begin
                  w_push     = 1'b1;
                  w_stack_we = 1'b1;
               end
            end else begin
               w_cnt_we    = 1'b1;
               w_cnt_wdata = r_cnt - c_c'(1);
            end
         end
         S_SET_RD: w_state_nxt = S_SET_WR;
         S_SET_WR: begin
            w_done      = 1'b1;
            w_state_nxt = S_DONE;
            if (r_cnt_q == '0) begin
               w_err = 1'b1;
            end else begin
               w_cnt_we    = 1'b1;
               w_cnt_wdata = r_cnt_in;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_stack_we) r_stack[w_stack_waddr] <= w_stack_wdata;
      if (w_cnt_we)   r_usecnt[w_cnt_waddr]  <= w_cnt_wdata;
      r_stack_q <= r_stack[w_stack_raddr];
      r_cnt_q   <= r_usecnt[r_addr];
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_INIT;
         r_init_idx <= '0;
         r_top      <= '0;
         r_last     <= c_pw'(c_p - 1);
         r_port     <= '0;
         r_force    <= 1'b0;
         r_addr     <= '0;
         r_cnt_in   <= '0;
         r_page     <= '0;
         r_cnt      <= '0;
         done_o     <= '0;
         err_o      <= 1'b0;
         pgaddr_o   <= '0;
         nomem_o    <= 1'b1;
         low_o      <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         done_o  <= w_done_vec;
         err_o   <= w_err;
         if (r_state == S_INIT) r_init_idx <= r_init_idx + c_a'(1);
         if (r_state == S_IDLE && w_any) begin
            r_port   <= w_sel;
            r_last   <= w_sel;
            r_force  <= force_free_i[w_sel];
            r_addr   <= pgaddr_i[w_sel*c_a +: c_a];
            r_cnt_in <= usecnt_i[w_sel*c_c +: c_c];
         end
         if (r_state == S_ALLOC_LAT) r_page <= r_stack_q;
         if (r_state == S_FREE_LAT)  r_cnt  <= r_cnt_q;
         if (w_pop) pgaddr_o <= r_page;
         r_top   <= w_top_nxt;
         nomem_o <= (w_top_nxt == '0);
         low_o   <= (w_top_nxt <= c_reserve);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_swc_multiport_page_allocator.sv
`default_nettype none
// ============================================================================
// tb_swc_multiport_page_allocator
//   Directed self-checking bench: 8 pages, 3 ports, reserve 2.
//   Rev 1.0 - initial release
// ============================================================================
module tb_swc_multiport_page_allocator;

   localparam int P = 3;
   localparam int N = 8;
   localparam int A = 11;
   localparam int C = 4;
   localparam int R = 2;
   localparam int K_ALLOC = 0, K_FREE = 1, K_FORCE = 2, K_SET = 3;

   logic             clk_i = 1'b0;
   logic             rst_n_i = 1'b0;
   logic [P-1:0]     alloc_i = '0, free_i = '0, force_free_i = '0, set_usecnt_i = '0;
   logic [P*A-1:0]   pgaddr_i = '0;
   logic [P*C-1:0]   usecnt_i = '0;
   logic [P-1:0]     done_o;
   logic [A-1:0]     pgaddr_o;
   logic             nomem_o, low_o, idle_o, err_o;
   logic [A:0]       free_count_o;

   int n_assert = 0;
   int n_fail   = 0;

   swc_multiport_page_allocator #(
      .g_num_ports(P), .g_num_pages(N), .g_page_addr_bits(A),
      .g_use_count_bits(C), .g_reserve_pages(R)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .alloc_i(alloc_i), .free_i(free_i), .force_free_i(force_free_i),
      .set_usecnt_i(set_usecnt_i), .pgaddr_i(pgaddr_i), .usecnt_i(usecnt_i),
      .done_o(done_o), .pgaddr_o(pgaddr_o), .nomem_o(nomem_o), .low_o(low_o),
      .free_count_o(free_count_o), .idle_o(idle_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request from one port; returns completion page, error flag and
   // number of clock edges from request to done_o.
   task automatic do_op(input int port, input int kind, input int addr, input int cnt,
                        output logic [31:0] page, output logic [31:0] err, output int lat);
      logic got;
      @(negedge clk_i);
      pgaddr_i[port*A +: A] = A'(addr);
      usecnt_i[port*C +: C] = C'(cnt);
      case (kind)
         K_ALLOC: alloc_i[port]      = 1'b1;
         K_FREE:  free_i[port]       = 1'b1;
         K_FORCE: force_free_i[port] = 1'b1;
         default: set_usecnt_i[port] = 1'b1;
      endcase
      got = 1'b0;
      lat = 0;
      while (!got && lat < 50) begin
         @(posedge clk_i); #1;
         lat++;
         if (done_o[port]) got = 1'b1;
      end
      check("op_done_seen", 32'(got), 32'd1);
      check("op_done_onehot", 32'(done_o), 32'(1 << port));
      page = 32'(pgaddr_o);
      err  = 32'(err_o);
      alloc_i = '0; free_i = '0; force_free_i = '0; set_usecnt_i = '0;
      @(posedge clk_i); #1;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (!idle_o && cycles < 100) begin
         @(posedge clk_i); #1;
         cycles++;
      end
      check("idle_reached", 32'(idle_o), 32'd1);
   endtask

   initial begin
      logic [31:0] pg, er;
      int lat, cyc, nev, fc;
      int ev_port [3];
      int ev_page [3];

      // Reset state
      #12;
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_pgaddr", 32'(pgaddr_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_idle", 32'(idle_o), 32'd0);
      check("rst_fc", 32'(free_count_o), 32'd0);
      check("rst_nomem", 32'(nomem_o), 32'd1);
      check("rst_low", 32'(low_o), 32'd1);

      @(negedge clk_i);
      rst_n_i = 1'b1;
      wait_idle(cyc);
      check("init_cycles", 32'(cyc), 32'd8);
      check("init_fc", 32'(free_count_o), 32'd8);
      check("init_nomem", 32'(nomem_o), 32'd0);
      check("init_low", 32'(low_o), 32'd0);

      // Three simultaneous allocs: served 0,1,2 with pages 0,1,2
      @(negedge clk_i);
      usecnt_i = {C'(1), C'(1), C'(1)};
      alloc_i  = 3'b111;
      nev = 0;
      for (int c = 0; c < 60 && nev < 3; c++) begin
         @(posedge clk_i); #1;
         if (done_o != '0) begin
            check("rr_onehot", 32'($onehot(done_o)), 32'd1);
            for (int k = 0; k < P; k++) if (done_o[k]) ev_port[nev] = k;
            ev_page[nev] = int'(pgaddr_o);
            alloc_i = alloc_i & ~done_o;
            nev++;
         end
      end
      check("rr_events", 32'(nev), 32'd3);
      for (int e = 0; e < 3; e++) begin
         check("rr_port", 32'(ev_port[e]), 32'(e));
         check("rr_page", 32'(ev_page[e]), 32'(e));
      end
      alloc_i = '0;
      @(posedge clk_i); #1;
      check("rr_fc", 32'(free_count_o), 32'd5);

      // Drain the rest from port 0: pages 3..7, low-water boundary at 2
      fc = 5;
      for (int i = 3; i < 8; i++) begin
         do_op(0, K_ALLOC, 0, 1, pg, er, lat);
         fc--;
         if (i == 3) check("alloc_latency", 32'(lat), 32'd4);
         check("alloc_page", pg, 32'(i));
         check("alloc_err", er, 32'd0);
         check("alloc_fc", 32'(free_count_o), 32'(fc));
         check("alloc_low", 32'(low_o), 32'(fc <= R));
      end
      check("empty_nomem", 32'(nomem_o), 32'd1);
      do_op(0, K_ALLOC, 0, 1, pg, er, lat);
      check("oom_err", er, 32'd1);
      check("oom_pgaddr_held", pg, 32'd7);
      check("oom_fc", 32'(free_count_o), 32'd0);

      // Use-count lifecycle on page 5
      do_op(1, K_FREE, 5, 0, pg, er, lat);
      check("free1_err", er, 32'd0);
      check("free1_latency", 32'(lat), 32'd4);
      check("free1_fc", 32'(free_count_o), 32'd1);
      check("free1_nomem", 32'(nomem_o), 32'd0);
      do_op(2, K_ALLOC, 0, 1, pg, er, lat);
      check("realloc_page", pg, 32'd5);
      do_op(0, K_SET, 5, 3, pg, er, lat);
      check("set_err", er, 32'd0);
      check("set_latency", 32'(lat), 32'd3);
      do_op(1, K_FREE, 5, 0, pg, er, lat);
      check("dec1_fc", 32'(free_count_o), 32'd0);
      do_op(1, K_FREE, 5, 0, pg, er, lat);
      check("dec2_fc", 32'(free_count_o), 32'd0);
      do_op(1, K_FREE, 5, 0, pg, er, lat);
      check("dec3_err", er, 32'd0);
      check("dec3_fc", 32'(free_count_o), 32'd1);
      do_op(2, K_SET, 5, 3, pg, er, lat);
      check("set_free_page_err", er, 32'd1);
      check("set_free_page_fc", 32'(free_count_o), 32'd1);
      do_op(0, K_ALLOC, 0, 1, pg, er, lat);
      check("lifo_page", pg, 32'd5);
      check("lifo_fc", 32'(free_count_o), 32'd0);

      // Force free ignores the count; then a second release of the same page
      do_op(1, K_SET, 5, 3, pg, er, lat);
      do_op(2, K_FORCE, 5, 0, pg, er, lat);
      check("force_err", er, 32'd0);
      check("force_fc", 32'(free_count_o), 32'd1);
      do_op(0, K_FREE, 5, 0, pg, er, lat);
`ifdef SWC_PALLOC_DBLFREE_CHECK_EN
      check("dblfree_err", er, 32'd1);
      check("dblfree_fc", 32'(free_count_o), 32'd1);
      fc = 1;
`else
      check("dblfree_err", er, 32'd0);
      check("dblfree_fc", 32'(free_count_o), 32'd2);
      fc = 2;
`endif

      // Alloc with use count 0 behaves as 1: a single free releases it
      do_op(1, K_ALLOC, 0, 0, pg, er, lat);
      check("cnt0_page", pg, 32'd5);
      check("cnt0_fc", 32'(free_count_o), 32'(fc - 1));
      do_op(1, K_FREE, 5, 0, pg, er, lat);
      check("cnt0_free_err", er, 32'd0);
      check("cnt0_free_fc", 32'(free_count_o), 32'(fc));

      // Asynchronous reset in the middle of an alloc
      @(negedge clk_i);
      usecnt_i[C-1:0] = C'(1);
      alloc_i[0] = 1'b1;
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_done", 32'(done_o), 32'd0);
      check("mid_rst_fc", 32'(free_count_o), 32'd0);
      check("mid_rst_nomem", 32'(nomem_o), 32'd1);
      check("mid_rst_low", 32'(low_o), 32'd1);
      check("mid_rst_idle", 32'(idle_o), 32'd0);
      check("mid_rst_pgaddr", 32'(pgaddr_o), 32'd0);
      alloc_i = '0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      wait_idle(cyc);
      check("reinit_cycles", 32'(cyc), 32'd8);
      check("reinit_fc", 32'(free_count_o), 32'd8);
      do_op(0, K_ALLOC, 0, 1, pg, er, lat);
      check("reinit_page", pg, 32'd0);
      check("reinit_alloc_fc", 32'(free_count_o), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/swc_multiport_page_allocator.md
Name: swc_multiport_page_allocator

Overview:
Shared page allocator for the switch core packet buffer, serving g_num_ports clients through round-robin arbitration.
- Keeps a LIFO free-page stack and a per-page use-count RAM.
- Supports alloc, free (use-count decrement), force free and set use count.
- Reports free-page count, an out-of-memory flag and a reserve low-water flag.
- Sits between the input-block page requesters and the multicast/output-block release logic.

Parameters:
g_num_ports, 4, number of client ports
g_num_pages, 2048, buffer pages; must not exceed 2**g_page_addr_bits
g_page_addr_bits, 11, page address width
g_use_count_bits, 4, use-count width
g_reserve_pages, 16, low-water threshold for low_o

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset; asynchronous, active-low
alloc_i  in  g_num_ports  per-port allocate request (level)
free_i  in  g_num_ports  per-port free request (level)
force_free_i  in  g_num_ports  per-port force-free request (level)
set_usecnt_i  in  g_num_ports  per-port set-use-count request (level)
pgaddr_i  in  g_num_ports*g_page_addr_bits  per-port page address; port k uses bits [k*A +: A]
usecnt_i  in  g_num_ports*g_use_count_bits  per-port use count for alloc/set
done_o  out  g_num_ports  one-cycle completion pulse to the granted port
pgaddr_o  out  g_page_addr_bits  allocated page; valid while done_o for an alloc
nomem_o  out  1  registered flag: free count == 0
low_o  out  1  registered flag: free count <= g_reserve_pages
free_count_o  out  g_page_addr_bits+1  current number of free pages
idle_o  out  1  FSM in S_IDLE and no request pending
err_o  out  1  one-cycle pulse on a rejected operation

Behaviour:
- Reset values: done_o=0, pgaddr_o=0, err_o=0, idle_o=0, free_count_o=0, nomem_o=1, low_o=1. Asynchronous assertion; any operation in flight is abandoned. The FSM re-enters S_INIT.
- S_INIT: writes stack[i]=g_num_pages-1-i and usecnt[i]=0 for i=0..g_num_pages-1, one entry per cycle.
  - free_count_o increments with each write.
  - Then enters S_IDLE. Init takes exactly g_num_pages cycles.
- S_IDLE: if any port has a request bit high, grant the next requesting port after the last granted one (round-robin, wrap at g_num_ports-1). The first grant after reset goes to port 0 side-first.
- Op priority within one port: force_free > free > set_usecnt > alloc.
- S_ALLOC: a read of stack[top-1] is issued, and the page is latched next cycle.
  - usecnt[page]=usecnt_i, top decrements, done_o and pgaddr_o are valid in the same cycle.
  - Latency from grant to done_o is 3 cycles. Pages come out 0,1,2,... after init, then LIFO.
  - If free count == 0: no pop, done_o with err_o, pgaddr_o unchanged.
  - A use count of 0 on alloc is treated as 1.
- S_FREE: read usecnt[pgaddr]; 3 cycles to done_o.
  - If >1: decrement and write back.
  - If ==1: write 0, push page, top increments.
- S_FORCE: write usecnt=0 and push the page regardless of count, unless the count is already 0; then behaves as for double free.
- S_SETCNT: usecnt[pgaddr]=usecnt_i; done_o after 2 cycles. No stack change. On a free page (count 0): err_o, no write.
- Handshake: a port holds its request until done_o[k]. It must drop the request in the cycle after done_o, or the request is re-granted.
- The FSM returns to S_IDLE the cycle after done_o, so at most one operation is in flight.
- free_count_o, nomem_o and low_o update the cycle after push/pop. free_count_o never exceeds g_num_pages and never wraps.

Optional Feature:
SWC_PALLOC_DBLFREE_CHECK_EN
- Defined: free/force_free of a page whose usecnt is 0 completes with done_o and err_o, no push, no count change.
- Undefined: that check is omitted and the page is pushed again (trusted-client build, smaller logic). set_usecnt on a free page is still rejected.

Test Plan:
- Bench parameters for all tests: g_num_pages=8, g_num_ports=3, g_reserve_pages=2.
- Reset release -> idle_o rises after 8 init cycles, free_count_o=8, nomem_o=0, low_o=0.
- Port 0 allocs 8 times with usecnt 1 -> pgaddr_o 0..7, free_count_o 0, nomem_o=1; 9th alloc -> done_o with err_o, free_count_o stays 0.
- Ports 0,1,2 request alloc in the same cycle -> done_o pulses in order port0, port1, port2 with pages 0,1,2; no port is granted twice.
- Alloc page p with usecnt 1, set_usecnt(3,p), free x3 -> page pushed only on the third free; the next alloc returns p.
- Set_usecnt(3,p) then force_free p -> single push, free_count_o +1. With SWC_PALLOC_DBLFREE_CHECK_EN, a further free p -> err_o, count unchanged.
- Assert rst_n_i mid-alloc -> outputs return to reset values immediately; after re-init free_count_o=8 and first alloc returns 0.
